// File: rtl/spike_event_arbiter.sv
// Merges spike events from NUM_SRC producers onto one shared spike bus.
// Each source has its own FIFO; a round-robin scheduler issues at most one event per clock.
module spike_event_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 8
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          enable,
  input  logic [NUM_SRC-1:0]                            src_valid,
  input  logic [NUM_SRC*ADDR_W-1:0]                     src_address,
  input  logic [NUM_SRC-1:0]                            src_on_off,
  output logic [NUM_SRC-1:0]                            src_ready,
  output logic                                          out_valid,
  output logic [ADDR_W-1:0]                             out_address,
  output logic                                          out_on_off,
  output logic [$clog2(NUM_SRC)-1:0]                    out_src_id,
  output logic [NUM_SRC*($clog2(FIFO_DEPTH)+1)-1:0]     fifo_level
);

  localparam int SRC_W = $clog2(NUM_SRC);
  localparam int IDX_W = $clog2(FIFO_DEPTH);
  localparam int PTR_W = IDX_W + 1;

  typedef struct packed {
    logic              on_off;
    logic [ADDR_W-1:0] address;
  } spike_t;

  spike_t           mem       [NUM_SRC][FIFO_DEPTH];
  spike_t           src_spike [NUM_SRC];
  logic [PTR_W-1:0] wr_ptr    [NUM_SRC];
  logic [PTR_W-1:0] rd_ptr    [NUM_SRC];
  logic [NUM_SRC-1:0] full, empty, push, pop;

  logic [SRC_W-1:0] rr_ptr;
  logic [SRC_W-1:0] cand;
  logic [SRC_W-1:0] grant_id;
  logic [SRC_W-1:0] next_ptr;
  logic             grant_valid;
  spike_t           head;

  // The extra pointer MSB distinguishes full (MSBs differ) from empty (all equal).
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign src_spike[i] = '{on_off: src_on_off[i], address: src_address[i*ADDR_W +: ADDR_W]};
    assign full[i]      = (wr_ptr[i] == {~rd_ptr[i][PTR_W-1], rd_ptr[i][IDX_W-1:0]});
    assign empty[i]     = (wr_ptr[i] == rd_ptr[i]);
    assign src_ready[i] = ~full[i];
    assign push[i]      = src_valid[i] & ~full[i];
    assign pop[i]       = grant_valid && (grant_id == SRC_W'(i));
    assign fifo_level[i*PTR_W +: PTR_W] = wr_ptr[i] - rd_ptr[i];
  end

  // Search order p, p+1, ... modulo NUM_SRC; registered FIFO state only, so no bypass.
  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = SRC_W'((int'(rr_ptr) + k) % NUM_SRC);
      if (enable && !grant_valid && !empty[cand]) begin
        grant_valid = 1'b1;
        grant_id    = cand;
      end
    end
  end

  assign head     = mem[grant_id][rd_ptr[grant_id][IDX_W-1:0]];
  assign next_ptr = (grant_id == SRC_W'(NUM_SRC - 1)) ? '0 : grant_id + 1'b1;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
      rr_ptr      <= '0;
      out_valid   <= 1'b0;
      out_address <= '0;
      out_on_off  <= 1'b0;
      out_src_id  <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
      end
      out_valid <= grant_valid;
      if (grant_valid) begin
        out_address <= head.address;
        out_on_off  <= head.on_off;
        out_src_id  <= grant_id;
        rr_ptr      <= next_ptr;
      end
    end
  end

  // NOTE: storage is not reset; the cleared pointers make any stale contents unreachable.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (push[i]) mem[i][wr_ptr[i][IDX_W-1:0]] <= src_spike[i];
    end
  end

endmodule

// File: tb/tb_spike_event_arbiter.sv
// Self-checking bench for spike_event_arbiter: queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed expected bus values.
module tb_spike_event_arbiter;

  localparam int NS = 4;
  localparam int FD = 4;
  localparam int AW = 8;
  localparam int LW = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic [NS-1:0]    src_valid;
  logic [NS*AW-1:0] src_address;
  logic [NS-1:0]    src_on_off;
  logic [NS-1:0]    src_ready;
  logic             out_valid;
  logic [AW-1:0]    out_address;
  logic             out_on_off;
  logic [1:0]       out_src_id;
  logic [NS*LW-1:0] fifo_level;

  spike_event_arbiter #(.NUM_SRC(NS), .FIFO_DEPTH(FD), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .src_valid(src_valid), .src_address(src_address), .src_on_off(src_on_off),
    .src_ready(src_ready), .out_valid(out_valid), .out_address(out_address),
    .out_on_off(out_on_off), .out_src_id(out_src_id), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one queue per source, round-robin pointer as a plain integer.
  logic [AW:0] q [NS][$];
  bit          m_valid = 1'b0;
  logic [AW-1:0] m_addr = '0;
  bit          m_on = 1'b0;
  int          m_id = 0;
  int          m_ptr = 0;
  bit [NS-1:0] m_acc;
  logic [AW:0] m_ev;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NS; i++) q[i].delete();
      m_valid = 1'b0; m_addr = '0; m_on = 1'b0; m_id = 0; m_ptr = 0;
    end else begin
      for (int i = 0; i < NS; i++) m_acc[i] = src_valid[i] && (q[i].size() < FD);
      m_valid = 1'b0;
      if (enable) begin
        for (int k = 0; k < NS; k++) begin
          int s;
          s = (m_ptr + k) % NS;
          if (!m_valid && q[s].size() > 0) begin
            m_ev    = q[s].pop_front();
            m_valid = 1'b1;
            m_on    = m_ev[AW];
            m_addr  = m_ev[AW-1:0];
            m_id    = s;
            m_ptr   = (s + 1) % NS;
          end
        end
      end
      for (int i = 0; i < NS; i++)
        if (m_acc[i]) q[i].push_back({src_on_off[i], src_address[i*AW +: AW]});
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      check("out_valid", 32'(out_valid), 32'(m_valid));
      check("out_address", 32'(out_address), 32'(m_addr));
      check("out_on_off", 32'(out_on_off), 32'(m_on));
      if (m_valid) check("out_src_id", 32'(out_src_id), 32'(m_id));
      for (int i = 0; i < NS; i++) begin
        check("src_ready", 32'(src_ready[i]), 32'(q[i].size() < FD));
        check("fifo_level", 32'(fifo_level[i*LW +: LW]), 32'(q[i].size()));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input int s, input logic [AW-1:0] a, input logic on);
    src_valid[s]            = 1'b1;
    src_address[s*AW +: AW] = a;
    src_on_off[s]           = on;
  endtask

  task automatic clear_src();
    src_valid = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic [AW-1:0] a, input logic on, input int id);
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_addr"}, 32'(out_address), 32'(a));
    check({name, "_on"}, 32'(out_on_off), 32'(on));
    check({name, "_id"}, 32'(out_src_id), 32'(id));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; enable = 1'b1;
    src_valid = '0; src_address = '0; src_on_off = '0;
    tick(); tick();
    reset = 1'b0;
    checking = 1'b1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ready", 32'(src_ready), 32'hF);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_addr", 32'(out_address), 32'd0);

    // Single event from source 2: visible exactly two edges after it is driven.
    drive(2, 8'h15, 1'b1);
    tick(); clear_src();
    check("single_early", 32'(out_valid), 32'd0);
    tick();
    expect_out("single", 8'h15, 1'b1, 2);
    tick();
    check("single_after", 32'(out_valid), 32'd0);

    // Simultaneous requests from all sources with pointer at 0.
    do_reset();
    for (int s = 0; s < NS; s++) drive(s, 8'hA0 + 8'(s), 1'b0);
    tick(); clear_src();
    for (int k = 0; k < NS; k++) begin
      tick();
      expect_out("simul", 8'hA0 + 8'(k), 1'b0, k);
    end
    tick();
    check("simul_done", 32'(out_valid), 32'd0);

    // Move pointer to 2, then src 1 and 3 each push three events back-to-back.
    drive(1, 8'h77, 1'b1);
    tick(); clear_src(); tick(); tick();
    begin
      int          exp_id [6];
      logic [7:0]  exp_a  [6];
      exp_id = '{3, 1, 3, 1, 3, 1};
      exp_a  = '{8'h30, 8'h10, 8'h31, 8'h11, 8'h32, 8'h12};
      for (int j = 0; j < 8; j++) begin
        if (j < 3) begin
          drive(1, 8'h10 + 8'(j), 1'b1);
          drive(3, 8'h30 + 8'(j), 1'b1);
        end else clear_src();
        tick();
        if (j >= 1 && j <= 6) expect_out("rr", exp_a[j-1], 1'b1, exp_id[j-1]);
      end
      check("rr_done", 32'(out_valid), 32'd0);
    end

    // Backpressure on source 0 while the scheduler is held.
    enable = 1'b0;
    for (int n = 0; n < 4; n++) begin
      drive(0, 8'h50 + 8'(n), 1'b1);
      tick();
    end
    check("bp_ready_low", 32'(src_ready[0]), 32'd0);
    check("bp_level_full", 32'(fifo_level[0 +: LW]), 32'd4);
    drive(0, 8'h54, 1'b1);
    tick(); tick();
    check("bp_still_full", 32'(fifo_level[0 +: LW]), 32'd4);
    check("bp_no_issue", 32'(out_valid), 32'd0);
    enable = 1'b1;
    tick();
    expect_out("bp0", 8'h50, 1'b1, 0);
    check("bp_ready_back", 32'(src_ready[0]), 32'd1);
    tick(); clear_src();
    expect_out("bp1", 8'h51, 1'b1, 0);
    check("bp_level_pushpop", 32'(fifo_level[0 +: LW]), 32'd3);
    for (int k = 2; k < 5; k++) begin
      tick();
      expect_out("bpk", 8'h50 + 8'(k), 1'b1, 0);
    end
    tick();
    check("bp_done", 32'(out_valid), 32'd0);

    // Hold: pointer is 1 after the backpressure drain; fill everything, hold 10 cycles.
    enable = 1'b0;
    for (int s = 0; s < NS; s++) drive(s, 8'hC0 + 8'(s), 1'b0);
    tick();
    for (int s = 0; s < NS; s++) drive(s, 8'hD0 + 8'(s), 1'b1);
    tick(); clear_src();
    for (int c = 0; c < 10; c++) begin
      tick();
      check("hold_valid", 32'(out_valid), 32'd0);
      check("hold_level", 32'(fifo_level), 32'h492);
    end
    enable = 1'b1;
    for (int k = 0; k < 8; k++) begin
      int s;
      s = (1 + k) % NS;
      tick();
      expect_out("hold_drain", (k < 4 ? 8'hC0 : 8'hD0) + 8'(s), k >= 4, s);
    end
    tick();
    check("hold_done", 32'(out_valid), 32'd0);

    // Reset in the middle of a burst.
    enable = 1'b0;
    for (int r = 0; r < 2; r++) begin
      for (int s = 0; s < 3; s++) drive(s, 8'hE0 + 8'(s) + 8'(r * 16), 1'b1);
      tick();
    end
    clear_src();
    enable = 1'b1;
    tick();
    expect_out("pre_reset", 8'hE1, 1'b1, 1);
    do_reset();
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_level", 32'(fifo_level), 32'd0);
    check("mid_rst_ready", 32'(src_ready), 32'hF);
    for (int c = 0; c < 6; c++) begin
      tick();
      check("post_rst_quiet", 32'(out_valid), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spike_event_arbiter.md
Name: spike_event_arbiter

Overview:
- Merges spike events from NUM_SRC independent producers onto the single shared spike bus (valid, address, on_off) that fans out to every synapse.
- Each producer feeds a small per-source FIFO. A round-robin scheduler drains the FIFOs at a rate of at most one event per clock.
- Sits between the input spike generators/router and the synapse array. Guarantees that the synapse address compare never sees two events in the same cycle.

Parameters:
- NUM_SRC, 4, number of requesting spike sources (2..16)
- FIFO_DEPTH, 4, entries per source FIFO (power of two, >=2)
- ADDR_W, 8, spike address width (matches synapse address field)

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- enable  input  1  1 = scheduler may issue events; 0 = hold (FIFOs still accept)
- src_valid  input  NUM_SRC  per-source event request
- src_address  input  NUM_SRC*ADDR_W  per-source target address; source i uses bits [i*ADDR_W +: ADDR_W]
- src_on_off  input  NUM_SRC  per-source polarity (1 = on/increment, 0 = off/decrement)
- src_ready  output  NUM_SRC  per-source FIFO not full
- out_valid  output  1  shared spike bus valid
- out_address  output  ADDR_W  shared spike bus address
- out_on_off  output  1  shared spike bus polarity
- out_src_id  output  $clog2(NUM_SRC)  index of the source that issued the current event
- fifo_level  output  NUM_SRC*($clog2(FIFO_DEPTH)+1)  per-source occupancy, for debug/monitoring

Behaviour:
- Reset values:
  - all FIFOs empty; src_ready all 1 in the first cycle after reset
  - out_valid=0, out_address=0, out_on_off=0, out_src_id=0
  - round-robin pointer=0; fifo_level all 0
- Reset mid-operation flushes all FIFOs. In-flight events are discarded, not issued.
- Input handshake:
  - an event from source i is accepted at the rising edge when src_valid[i] && src_ready[i]
  - src_ready[i] = !full[i], a pure function of the registered FIFO state; no combinational path from src_valid
  - a full FIFO accepts nothing, even if it is popped in the same cycle; ready rises the cycle after the pop
  - sources hold valid/address/on_off until accepted
- FIFO: one per source, FIFO_DEPTH entries of {on_off, address}. Same-cycle push and pop on a non-full, non-empty FIFO leaves the level unchanged.
- Scheduler, evaluated every cycle with enable=1:
  - candidates are sources whose FIFO is non-empty (registered state, so no same-cycle bypass)
  - search order starts at pointer p: p, p+1, ..., wrapping modulo NUM_SRC
  - the first candidate g is granted: its FIFO head is popped
  - out_* are registered with out_valid=1, out_src_id=g, and the pointer becomes (g+1) mod NUM_SRC
  - if there is no candidate: out_valid=0, pointer unchanged, out_address/out_on_off hold their last values
- enable=0: no grant, out_valid=0 next cycle, pointer unchanged, FIFOs keep filling until full.
- Latency: an event accepted at edge t appears on out_* after edge t+1 (2-cycle minimum latency) when its source is granted immediately.
- Throughput: one event per cycle on out_*; out_valid may stay high on consecutive cycles.
- Fairness: with all sources continuously non-empty, grants cycle 0,1,...,NUM_SRC-1,0,...
  - each source is served within NUM_SRC cycles of becoming head-of-line
- Per-source ordering is preserved (FIFO order). Cross-source order follows the round-robin arbitration only.
- Wrap-around: FIFO read/write pointers use an extra MSB for the full/empty distinction. fifo_level ranges 0..FIFO_DEPTH.

Test Plan:
- Single event: src 2 sends addr=0x15, on_off=1 at cycle 5 → out_valid=1, out_address=0x15, out_on_off=1, out_src_id=2 in cycle 7 only; otherwise out_valid=0.
- Simultaneous requests: all 4 sources push one event in the same cycle (addrs 0xA0..0xA3) → four consecutive out_valid cycles issuing 0xA0, 0xA1, 0xA2, 0xA3 (src 0..3); pointer ends at 0.
- Round-robin fairness: src 1 and src 3 each push 3 events back-to-back, pointer=2 → issue order 3,1,3,1,3,1 with out_valid continuous.
- Backpressure: enable=0, src 0 pushes 5 events → first 4 accepted, src_ready[0]=0 after the 4th, fifo_level[0]=4. Raise enable → 4 events issued in order; src_ready[0] returns to 1 the cycle after the first pop, and the 5th event is accepted.
- Hold: enable low for 10 cycles with all FIFOs holding events → out_valid=0 throughout, no FIFO level decreases. Enable high → draining resumes from the unchanged pointer.
- Reset mid-burst: 3 FIFOs non-empty, reset asserted for 1 cycle → out_valid=0, fifo_level all 0, src_ready all 1 the next cycle, no pre-reset event issued afterwards.
